// File: rtl/switch_pkg.sv
// Shared constants, scan FSM state type and byte-group helper for the switch front end.
package switch_pkg;

  localparam int unsigned SW_WIDTH     = 64;
  localparam int unsigned SW_GROUPS    = 8;
  localparam int unsigned SW_GRP_W     = 8;
  localparam int unsigned SW_GRP_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } scan_state_e;

  typedef logic [SW_GRP_W-1:0]     grp_byte_t;
  typedef logic [SW_GRP_IDX_W-1:0] grp_idx_t;

  function automatic grp_byte_t get_byte(input logic [SW_WIDTH-1:0] word, input grp_idx_t grp);
    return word[int'(grp)*SW_GRP_W +: SW_GRP_W];
  endfunction

endpackage

// File: rtl/switch_tick_gen.sv
// Free-running sample tick: o_tick is high for one cycle every TICK_DIV clocks.
module switch_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic Clk,
  input  logic Reset,
  output logic o_tick
);

  localparam int unsigned       CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/switch_scan_ctrl.sv
// Synchronises and debounces 64 switch pins in 8 byte groups, committing Wd atomically.
// Define SWITCH_SCAN_ACTIVE_LOW_EN to treat the pins as active-low.
module switch_scan_ctrl
  import switch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [SW_WIDTH-1:0] RawSw,
  output logic [SW_WIDTH-1:0] Wd,
  output logic                Update,
  output logic                Busy
);

  localparam int unsigned     CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT);
  localparam grp_idx_t        GRP_LAST = SW_GRP_IDX_W'(SW_GROUPS - 1);

  logic [SW_WIDTH-1:0] w_raw;
  logic [SW_WIDTH-1:0] r_sync1, r_sync2, r_snap;
  grp_byte_t           r_cand   [SW_GROUPS];
  logic [CNT_W-1:0]    r_cnt    [SW_GROUPS];
  grp_byte_t           r_shadow [SW_GROUPS];
  logic                r_dirty;
  scan_state_e         r_state;
  grp_idx_t            r_grp;
  logic [SW_WIDTH-1:0] r_wd;
  logic                r_update, r_busy;

  logic                w_tick;
  grp_byte_t           w_byte, w_cand_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_commit;
  logic [SW_WIDTH-1:0] w_shadow_word;

`ifdef SWITCH_SCAN_ACTIVE_LOW_EN
  assign w_raw = ~RawSw;
`else
  assign w_raw = RawSw;
`endif

  switch_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .Clk    (Clk),
    .Reset  (Reset),
    .o_tick (w_tick)
  );

  // Debounce step for the group currently addressed by r_grp.
  always_comb begin
    w_byte      = get_byte(r_snap, r_grp);
    w_cand_next = r_cand[r_grp];
    w_cnt_next  = CNT_W'(1);
    if (w_byte == r_cand[r_grp]) begin
      w_cnt_next = (r_cnt[r_grp] >= CNT_MAX) ? CNT_MAX : r_cnt[r_grp] + CNT_W'(1);
    end else begin
      w_cand_next = w_byte;
    end
    w_commit = (w_cnt_next == CNT_MAX) && (w_cand_next != r_shadow[r_grp]);
  end

  always_comb begin
    w_shadow_word = '0;
    for (int g = 0; g < SW_GROUPS; g++) begin
      w_shadow_word[g*SW_GRP_W +: SW_GRP_W] = r_shadow[g];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_snap   <= '0;
      r_dirty  <= 1'b0;
      r_state  <= IDLE;
      r_grp    <= '0;
      r_wd     <= '0;
      r_update <= 1'b0;
      r_busy   <= 1'b0;
      for (int g = 0; g < SW_GROUPS; g++) begin
        r_cand[g]   <= '0;
        r_cnt[g]    <= '0;
        r_shadow[g] <= '0;
      end
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_update <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // One snapshot per tick so every group sees the same sample instant.
          if (w_tick) begin
            r_state <= SCAN;
            r_grp   <= '0;
            r_snap  <= r_sync2;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          r_cand[r_grp] <= w_cand_next;
          r_cnt[r_grp]  <= w_cnt_next;
          if (w_commit) begin
            r_shadow[r_grp] <= w_cand_next;
            r_dirty         <= 1'b1;
          end
          if (r_grp == GRP_LAST) begin
            r_state <= COMMIT;
          end
          r_grp <= r_grp + SW_GRP_IDX_W'(1);
        end
        COMMIT: begin
          if (r_dirty) begin
            r_wd     <= w_shadow_word;
            r_update <= 1'b1;
            r_dirty  <= 1'b0;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Wd     = r_wd;
  assign Update = r_update;
  assign Busy   = r_busy;

  a_tick_only_in_idle: assert property (@(posedge Clk) disable iff (Reset)
    w_tick |-> (r_state == IDLE));

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Directed bench for switch_scan_ctrl with TICK_DIV=16, STABLE_CNT=3; one table row per tick period.
module tb_switch_scan_ctrl;
  import switch_pkg::*;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] RawSw = '0;
  logic [63:0] Wd;
  logic        Update;
  logic        Busy;

  switch_scan_ctrl #(
    .TICK_DIV   (16),
    .STABLE_CNT (3)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .RawSw  (RawSw),
    .Wd     (Wd),
    .Update (Update),
    .Busy   (Busy)
  );

  always #5 Clk = ~Clk;

  // pre: 0 none, 1 mid-scan reset sequence first, 2 plain reset first
  typedef struct {
    logic [63:0] raw;
    int          n_upd;
    logic [63:0] wd;
    int          pre;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] W3 = 64'h0000_0000_3C00_00A5;
  localparam logic [63:0] W4 = 64'h0066_0000_3C00_11A5;
  localparam logic [63:0] WF = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] to_pins(input logic [63:0] v);
`ifdef SWITCH_SCAN_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic void add(input logic [63:0] raw, input int n, input logic [63:0] wd,
                              input int pre);
    vec_t v;
    v.raw = raw;
    v.n_upd = n;
    v.wd = wd;
    v.pre = pre;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 16 clocks from a negedge; the tick lands on the 6th edge of the window.
  task automatic run_period(input logic [63:0] raw, output int n_upd, output int n_busy,
                            output int n_bad, output logic [63:0] wd_end);
    logic [63:0] prev;
    RawSw  = to_pins(raw);
    prev   = Wd;
    n_upd  = 0;
    n_busy = 0;
    n_bad  = 0;
    repeat (16) begin
      @(negedge Clk);
      if (Update) n_upd++;
      if (Busy) n_busy++;
      if ((Wd !== prev) != (Update === 1'b1)) n_bad++;
      prev = Wd;
    end
    wd_end = Wd;
  endtask

  task automatic release_reset();
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic mid_scan_reset();
    repeat (10) @(negedge Clk);
    check("busy_before_reset", 64'(Busy), 64'd1);
    check("grp_before_reset", 64'(dut.r_grp), 64'd4);
    check("wd_before_reset", Wd, WF);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_mid_wd", Wd, 64'd0);
    check("rst_mid_update", 64'(Update), 64'd0);
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_state", 64'(dut.r_state), 64'(IDLE));
    release_reset();
  endtask

  initial begin
    int          n_upd, n_busy, n_bad;
    logic [63:0] wd_end;

    // Idle pins
    for (int i = 0; i < 10; i++) add(64'd0, 0, 64'd0, 0);
    // Clean change on byte 0, then saturation
    add(64'hA5, 0, 64'd0, 0);
    add(64'hA5, 0, 64'd0, 0);
    add(64'hA5, 1, 64'hA5, 0);
    add(64'hA5, 0, 64'hA5, 0);
    // Bounce on byte 3, then hold
    for (int i = 0; i < 6; i++) add((i % 2 == 0) ? W3 : 64'hA5, 0, 64'hA5, 0);
    add(W3, 0, 64'hA5, 0);
    add(W3, 0, 64'hA5, 0);
    add(W3, 1, W3, 0);
    // Two bytes change together
    add(W4, 0, W3, 0);
    add(W4, 0, W3, 0);
    add(W4, 1, W4, 0);
    add(W4, 0, W4, 0);
    // All ones, then reset mid-scan and recommit
    add(WF, 0, W4, 0);
    add(WF, 0, W4, 0);
    add(WF, 1, WF, 0);
    add(WF, 0, 64'd0, 1);
    add(WF, 0, 64'd0, 0);
    add(WF, 1, WF, 0);
    // Released pins after reset, then bit 0 pressed
    add(64'd0, 0, 64'd0, 2);
    for (int i = 0; i < 3; i++) add(64'd0, 0, 64'd0, 0);
    add(64'd1, 0, 64'd0, 0);
    add(64'd1, 0, 64'd0, 0);
    add(64'd1, 1, 64'd1, 0);
    add(64'd1, 0, 64'd1, 0);

    RawSw = to_pins(64'd0);
    repeat (3) @(negedge Clk);
    check("rst_wd", Wd, 64'd0);
    check("rst_update", 64'(Update), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    release_reset();

    foreach (vecs[i]) begin
      if (vecs[i].pre == 1) begin
        mid_scan_reset();
      end else if (vecs[i].pre == 2) begin
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst2_wd", Wd, 64'd0);
        release_reset();
      end
      run_period(vecs[i].raw, n_upd, n_busy, n_bad, wd_end);
      check($sformatf("row%0d_updates", i), 64'(n_upd), 64'(vecs[i].n_upd));
      check($sformatf("row%0d_wd", i), wd_end, vecs[i].wd);
      check($sformatf("row%0d_busy_cycles", i), 64'(n_busy), 64'd9);
      check($sformatf("row%0d_wd_vs_update", i), 64'(n_bad), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
